bcd_display_engine: RTL and testbench
=====================================

Name: bcd_display_engine

Overview:
- Parametrised successor to the fixed 16-bit binary-to-BCD display path.
- Converts a WIDTH-bit binary value to DIGITS BCD nibbles using a sequential double-dabble engine, one shift per clock.
- Adds a one-deep pending buffer, a debounced freeze toggle driven by the push button, and optional leading-zero blanking.
- Sits between the hasher output and the 7-segment digit outputs.

Parameters:
- WIDTH, 16: binary input width. Legal range 4..32.
- DIGITS, 5: number of BCD digits. Must satisfy 10^DIGITS > 2^WIDTH-1; elaboration error otherwise.
- BLANK_LZ, 0: when 1, leading zero digits output 4'hF (blank). Digit 0 is never blanked.
- DEB_SAMPLES, 2: number of consecutive equal tick-samples required to accept a button level. Legal range 1..8.

Ports:
- sysclk  input  1  system clock (1 MHz)
- rst_n  input  1  asynchronous, active-low reset
- tick  input  1  single-cycle sample enable for the button (500 Hz strobe from the clock divider)
- button_in  input  1  raw push button, asynchronous to tick
- value_in  input  WIDTH  binary value to convert
- value_valid  input  1  request to convert value_in this cycle
- bcd_out  output  4*DIGITS  displayed digits; digit 0 (least significant) at [3:0]
- busy  output  1  conversion engine running
- done  output  1  one-cycle pulse when a conversion completes
- frozen  output  1  display hold active

Behaviour:
- Reset (async assert, sync release):
  - Display register = 0; busy=0, done=0, frozen=0, pending empty, button FSM in IDLE.
  - With BLANK_LZ=1, the reset display is F..F0.
- Button FSM, evaluated only on cycles with tick=1:
  - Input is 2-flop synchronised before sampling.
  - States: IDLE, PRESS_CNT, HELD, REL_CNT.
  - IDLE -> PRESS_CNT on a sampled 1.
  - PRESS_CNT counts consecutive 1 samples. A 0 sample returns to IDLE. Reaching DEB_SAMPLES -> HELD and toggles frozen in the same cycle.
  - HELD -> REL_CNT on a sampled 0.
  - REL_CNT counts consecutive 0 samples. A 1 sample returns to HELD. Reaching DEB_SAMPLES -> IDLE.
  - Exactly one toggle per accepted press. Holding the button never retoggles.
- Accept rules:
  - value_valid with busy=0 and pending empty: load the engine in that cycle. busy=1 from the next cycle.
  - value_valid with busy=1: write value_in to the pending register. A newer request overwrites an older pending value (latest wins). No request is dropped except by overwrite.
  - When the engine finishes with pending full: the pending value is loaded in the done cycle and pending is cleared. There is no idle cycle between conversions.
  - If value_valid coincides with that reload: the reload takes the pending value and value_in becomes the new pending value.
- Engine:
  - Shift register of 4*DIGITS+WIDTH bits.
  - Each cycle, add 3 to every BCD nibble >=5, then shift left 1. Runs WIDTH cycles.
  - done pulses in the cycle after the final shift. Latency from the accept cycle to done is WIDTH+1 cycles; busy is high for WIDTH cycles.
  - Arithmetic is unsigned. The input is zero-extended; no overflow is possible given the DIGITS constraint.
- Display update:
  - On done with frozen=0, the display register loads the result, visible on bcd_out the next cycle.
  - On done with frozen=1, the result goes to a shadow register and the display is held.
  - On frozen 1->0, the display loads the shadow in the next cycle if a newer result exists; otherwise it stays unchanged.
  - If the 1->0 transition and done coincide, the new result wins.
- Blanking:
  - Combinational on the display register.
  - Scanning from the MS digit, each zero digit is replaced by F until the first nonzero digit. Digit 0 is always shown.
- Reset mid-conversion:
  - Aborts the conversion and clears pending. No done pulse is issued.
  - The display returns to 0 (or F..F0 with BLANK_LZ=1).

Test Plan:
- Max value: WIDTH=16, DIGITS=5. value_in=16'hFFFF pulsed at cycle 0 -> done at cycle 17; bcd_out=20'h65535 at cycle 18.
- Zero with blanking: BLANK_LZ=1, value 0 -> bcd_out=20'hFFFF0. Then value 16'd42 -> 20'hFFF42.
- Back-to-back requests: request 100 at cycle 0, then 200 at cycle 3 and 300 at cycle 5 while busy.
  - done at 17 shows 00100; done at 34 shows 00300.
  - 200 is never displayed; busy stays high with no gap between the two conversions.
- Debounce: DEB_SAMPLES=2. A button bounce of a single high sample -> frozen stays 0. A clean hold for 5 ticks -> frozen=1 exactly once. Release and a second press -> frozen=0.
- Freeze and release:
  - frozen=1 with 12345 displayed; convert 54321 -> bcd_out stays 12345.
  - Unfreeze -> bcd_out=54321 one cycle after frozen falls.
- Reset mid-conversion: assert rst_n low at cycle 8 of a conversion -> busy=0, bcd_out=0 immediately, and no done pulse follows after release.

Source files
------------

// File: rtl/bcd_display_engine_if.sv
`timescale 1ns/1ps
// bcd_display_engine_if
// Conversion request / display bundle between the value source (hasher side)
// and the BCD display engine.
//   value_in    : binary value to convert            (master -> slave)
//   value_valid : request to convert value_in        (master -> slave)
//   bcd_out     : displayed digits, digit 0 at [3:0] (slave -> master)
//   busy        : conversion engine running          (slave -> master)
//   done        : one-cycle conversion-complete pulse (slave -> master)
//   frozen      : display hold active                (slave -> master)
interface bcd_display_engine_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic [WIDTH-1:0]    value_in;
   logic                value_valid;
   logic [4*DIGITS-1:0] bcd_out;
   logic                busy;
   logic                done;
   logic                frozen;

   modport master (
      output value_in, value_valid,
      input  bcd_out, busy, done, frozen
   );

   modport slave (
      input  value_in, value_valid,
      output bcd_out, busy, done, frozen
   );
endinterface

// File: rtl/bcd_display_engine.sv
`timescale 1ns/1ps
// bcd_display_engine
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment
// digits, with a one-deep latest-wins pending request, a debounced freeze
// toggle on the push button and optional leading-zero blanking.
// Ports:
//   sysclk    : system clock
//   rst_n     : asynchronous active-low reset (released synchronously inside)
//   tick      : single-cycle button sample strobe
//   button_in : raw push button, asynchronous
//   bus       : request/display bundle (see bcd_display_engine_if)
module bcd_display_engine #(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter int BLANK_LZ    = 0,
   parameter int DEB_SAMPLES = 2
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 button_in,
   bcd_display_engine_if.slave  bus
);

   localparam int BCD_W = 4*DIGITS;
   localparam int SH_W  = BCD_W + WIDTH;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   // Parameter legality is checked at elaboration time.
   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("bcd_display_engine: WIDTH must be in 4..32");
   end
   if (DIGITS < 1 || DIGITS > 19) begin : g_bad_digits_range
      $error("bcd_display_engine: DIGITS must be in 1..19");
   end else if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
      $error("bcd_display_engine: DIGITS too small for WIDTH");
   end
   if (DEB_SAMPLES < 1 || DEB_SAMPLES > 8) begin : g_bad_deb
      $error("bcd_display_engine: DEB_SAMPLES must be in 1..8");
   end

   // Reset: asserts asynchronously, releases two clocks later in sync with sysclk.
   logic [1:0] rst_pipe;
   logic       rst_int_n;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

   assign rst_int_n = rst_pipe[1];

   // ---------------------------------------------------------------------
   // Conversion engine and pending buffer
   // ---------------------------------------------------------------------
   logic [SH_W-1:0]  sh;
   logic [SH_W-1:0]  sh_adj;
   logic [CNT_W-1:0] shift_cnt;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] pend_val;
   logic             pend_full;
   logic [BCD_W-1:0] result;

   // Add 3 to every BCD nibble that is 5 or more before the shift.
   always_comb begin
      sh_adj = sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (sh[WIDTH+4*i +: 4] >= 4'd5) sh_adj[WIDTH+4*i +: 4] = sh[WIDTH+4*i +: 4] + 4'd3;
      end
   end

   assign result = sh[SH_W-1 -: BCD_W];

   // busy stays high through the done cycle when a pending value is about
   // to be reloaded, so back-to-back conversions show no gap. During that
   // done cycle the shift register holds the finished result unshifted.
   always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sh        <= '0;
         shift_cnt <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pend_val  <= '0;
         pend_full <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (done_r && pend_full) begin
            sh        <= {{BCD_W{1'b0}}, pend_val};
            shift_cnt <= '0;
            busy_r    <= 1'b1;
            pend_full <= bus.value_valid;
            if (bus.value_valid) pend_val <= bus.value_in;
         end else if (bus.value_valid && !busy_r && !pend_full) begin
            sh        <= {{BCD_W{1'b0}}, bus.value_in};
            shift_cnt <= '0;
            busy_r    <= 1'b1;
         end else if (busy_r) begin
            if (bus.value_valid) begin
               pend_val  <= bus.value_in;
               pend_full <= 1'b1;
            end
            sh        <= {sh_adj[SH_W-2:0], 1'b0};
            shift_cnt <= shift_cnt + 1'b1;
            if (shift_cnt == CNT_W'(WIDTH-1)) begin
               done_r <= 1'b1;
               busy_r <= pend_full | bus.value_valid;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Button synchroniser and debounce FSM
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, REL_CNT} btn_state_t;

   btn_state_t btn_state;
   logic       btn_meta;
   logic       btn_sync;
   logic [3:0] deb_cnt;
   logic       frozen_r;

   always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         btn_meta <= button_in;
         btn_sync <= btn_meta;
      end
   end

   // The sample that leaves IDLE (or HELD) counts as the first of the run,
   // so DEB_SAMPLES equal samples in total are needed to change level.
   always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         btn_state <= IDLE;
         deb_cnt   <= 4'd0;
         frozen_r  <= 1'b0;
      end else if (tick) begin
         case (btn_state)
            IDLE: begin
               if (btn_sync) begin
                  if (DEB_SAMPLES == 1) begin
                     btn_state <= HELD;
                     frozen_r  <= ~frozen_r;
                  end else begin
                     btn_state <= PRESS_CNT;
                     deb_cnt   <= 4'd1;
                  end
               end
            end
            PRESS_CNT: begin
               if (!btn_sync) begin
                  btn_state <= IDLE;
               end else if (deb_cnt + 4'd1 == 4'(DEB_SAMPLES)) begin
                  btn_state <= HELD;
                  frozen_r  <= ~frozen_r;
               end else begin
                  deb_cnt <= deb_cnt + 4'd1;
               end
            end
            HELD: begin
               if (!btn_sync) begin
                  if (DEB_SAMPLES == 1) begin
                     btn_state <= IDLE;
                  end else begin
                     btn_state <= REL_CNT;
                     deb_cnt   <= 4'd1;
                  end
               end
            end
            REL_CNT: begin
               if (btn_sync) begin
                  btn_state <= HELD;
               end else if (deb_cnt + 4'd1 == 4'(DEB_SAMPLES)) begin
                  btn_state <= IDLE;
               end else begin
                  deb_cnt <= deb_cnt + 4'd1;
               end
            end
            default: btn_state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Display and shadow registers
   // ---------------------------------------------------------------------
   logic [BCD_W-1:0] disp;
   logic [BCD_W-1:0] shadow;
   logic             shadow_new;
   logic             frozen_q;

   // A fresh result always wins over replaying the shadow on unfreeze.
   always_ff @(posedge sysclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         disp       <= '0;
         shadow     <= '0;
         shadow_new <= 1'b0;
         frozen_q   <= 1'b0;
      end else begin
         frozen_q <= frozen_r;
         if (done_r) begin
            if (!frozen_r) begin
               disp       <= result;
               shadow_new <= 1'b0;
            end else begin
               shadow     <= result;
               shadow_new <= 1'b1;
            end
         end else if (frozen_q && !frozen_r && shadow_new) begin
            disp       <= shadow;
            shadow_new <= 1'b0;
         end
      end
   end

   // Leading-zero blanking: scan down from the MS digit, digit 0 always shown.
   logic [BCD_W-1:0] shown;
   logic             leading;

   always_comb begin
      shown   = disp;
      leading = 1'b1;
      if (BLANK_LZ != 0) begin
         for (int i = DIGITS-1; i >= 1; i--) begin
            if (leading && (disp[4*i +: 4] == 4'd0)) shown[4*i +: 4] = 4'hF;
            else                                      leading = 1'b0;
         end
      end
   end

   assign bus.bcd_out = shown;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.frozen  = frozen_r;

endmodule

// File: tb/tb_bcd_display_engine.sv
`timescale 1ns/1ps
// tb_bcd_display_engine
// Scoreboard bench: stimulus pushes the expected post-done display into a
// queue per DUT; monitors pop and compare one cycle after each done pulse.
// dut_a runs without blanking, dut_b with leading-zero blanking; both share
// stimulus, tick and button.
module tb_bcd_display_engine;

   logic sysclk = 1'b0;
   logic rst_n;
   logic tick;
   logic button_in;

   int errors = 0;
   int checks = 0;
   int done_seen_a = 0;
   int done_seen_b = 0;

   logic [19:0] q_a[$];
   logic [19:0] q_b[$];

   bcd_display_engine_if #(.WIDTH(16), .DIGITS(5)) bus_a ();
   bcd_display_engine_if #(.WIDTH(16), .DIGITS(5)) bus_b ();

   assign bus_b.value_in    = bus_a.value_in;
   assign bus_b.value_valid = bus_a.value_valid;

   bcd_display_engine #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0), .DEB_SAMPLES(2)) dut_a (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .tick      (tick),
      .button_in (button_in),
      .bus       (bus_a)
   );

   bcd_display_engine #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1), .DEB_SAMPLES(2)) dut_b (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .tick      (tick),
      .button_in (button_in),
      .bus       (bus_b)
   );

   always #5 sysclk = ~sysclk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulse a request in one cycle (cycle 0); returns at cycle 1.
   task automatic applyStimulus(input logic [15:0] value, input bit push,
                                input logic [19:0] exp_a, input logic [19:0] exp_b);
      @(negedge sysclk);
      bus_a.value_in    = value;
      bus_a.value_valid = 1'b1;
      if (push) begin
         q_a.push_back(exp_a);
         q_b.push_back(exp_b);
      end
      @(negedge sysclk);
      bus_a.value_valid = 1'b0;
   endtask

   // Called at cycle 1; counts cycles until done, bounded.
   task automatic waitDone(input string name);
      int cyc;
      cyc = 1;
      checkOutput({name, "_busy_after_accept"}, bus_a.busy, 1);
      while (!bus_a.done && cyc < 60) begin
         @(negedge sysclk);
         cyc++;
      end
      checkOutput({name, "_done_latency"}, cyc, 17);
      checkOutput({name, "_busy_at_done"}, bus_a.busy, 0);
      repeat (3) @(negedge sysclk);
   endtask

   task automatic doTick();
      repeat (3) @(negedge sysclk);
      tick = 1'b1;
      @(negedge sysclk);
      tick = 1'b0;
   endtask

   // Monitors: display is valid the cycle after done.
   initial begin
      logic [19:0] exp;
      forever begin
         @(negedge sysclk);
         if (bus_a.done === 1'b1) begin
            done_seen_a++;
            @(negedge sysclk);
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done_a: got done with bcd_out %0h, expected no done", bus_a.bcd_out);
            end else begin
               exp = q_a.pop_front();
               checkOutput("display_a", bus_a.bcd_out, exp);
            end
         end
      end
   end

   initial begin
      logic [19:0] exp;
      forever begin
         @(negedge sysclk);
         if (bus_b.done === 1'b1) begin
            done_seen_b++;
            @(negedge sysclk);
            if (q_b.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done_b: got done with bcd_out %0h, expected no done", bus_b.bcd_out);
            end else begin
               exp = q_b.pop_front();
               checkOutput("display_b", bus_b.bcd_out, exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int first_done, second_done, gaps, saved_a, saved_b;
      logic busy_34;

      rst_n             = 1'b0;
      tick              = 1'b0;
      button_in         = 1'b0;
      bus_a.value_in    = '0;
      bus_a.value_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge sysclk);
      checkOutput("reset_busy", bus_a.busy, 0);
      checkOutput("reset_done", bus_a.done, 0);
      checkOutput("reset_frozen", bus_a.frozen, 0);
      checkOutput("reset_bcd_a", bus_a.bcd_out, 20'h00000);
      checkOutput("reset_bcd_b", bus_b.bcd_out, 20'hFFFF0);
      rst_n = 1'b1;
      repeat (4) @(negedge sysclk);

      // Max value
      applyStimulus(16'hFFFF, 1'b1, 20'h65535, 20'h65535);
      waitDone("max");

      // Zero and small value, blanked on dut_b
      applyStimulus(16'd0, 1'b1, 20'h00000, 20'hFFFF0);
      waitDone("zero");
      applyStimulus(16'd42, 1'b1, 20'h00042, 20'hFFF42);
      waitDone("val42");

      // Back-to-back: 100 at c0, 200 at c3, 300 at c5 (200 overwritten)
      first_done  = -1;
      second_done = -1;
      gaps        = 0;
      busy_34     = 1'b1;
      @(negedge sysclk);
      bus_a.value_in    = 16'd100;
      bus_a.value_valid = 1'b1;
      q_a.push_back(20'h00100);
      q_b.push_back(20'hFF100);
      for (int c = 1; c <= 40; c++) begin
         @(negedge sysclk);
         bus_a.value_valid = 1'b0;
         if (c == 3) begin
            bus_a.value_in    = 16'd200;
            bus_a.value_valid = 1'b1;
         end
         if (c == 5) begin
            bus_a.value_in    = 16'd300;
            bus_a.value_valid = 1'b1;
            q_a.push_back(20'h00300);
            q_b.push_back(20'hFF300);
         end
         if (bus_a.done) begin
            if (first_done < 0) first_done = c;
            else if (second_done < 0) second_done = c;
         end
         if (c <= 33 && !bus_a.busy) gaps++;
         if (c == 34) busy_34 = bus_a.busy;
      end
      checkOutput("b2b_first_done", first_done, 17);
      checkOutput("b2b_second_done", second_done, 34);
      checkOutput("b2b_busy_gaps", gaps, 0);
      checkOutput("b2b_busy_after", busy_34, 0);

      // Debounce: single-sample bounce does nothing
      button_in = 1'b1;
      doTick();
      button_in = 1'b0;
      doTick();
      checkOutput("bounce_frozen", bus_a.frozen, 0);
      // Clean hold of 5 ticks toggles exactly once
      button_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         doTick();
         checkOutput($sformatf("hold_frozen_t%0d", k), bus_a.frozen, (k >= 2) ? 1 : 0);
      end
      button_in = 1'b0;
      doTick();
      doTick();
      checkOutput("release_frozen", bus_a.frozen, 1);
      button_in = 1'b1;
      doTick();
      doTick();
      checkOutput("second_press_frozen", bus_a.frozen, 0);
      button_in = 1'b0;
      doTick();
      doTick();

      // Freeze and release
      applyStimulus(16'd12345, 1'b1, 20'h12345, 20'h12345);
      waitDone("val12345");
      button_in = 1'b1;
      doTick();
      doTick();
      button_in = 1'b0;
      doTick();
      doTick();
      checkOutput("freeze_frozen", bus_a.frozen, 1);
      applyStimulus(16'd54321, 1'b1, 20'h12345, 20'h12345);
      waitDone("frozen_conv");
      checkOutput("freeze_hold", bus_a.bcd_out, 20'h12345);
      button_in = 1'b1;
      doTick();
      repeat (3) @(negedge sysclk);
      tick = 1'b1;
      @(negedge sysclk);
      tick = 1'b0;
      checkOutput("unfreeze_frozen", bus_a.frozen, 0);
      checkOutput("unfreeze_still_old", bus_a.bcd_out, 20'h12345);
      @(negedge sysclk);
      checkOutput("unfreeze_shadow_a", bus_a.bcd_out, 20'h54321);
      checkOutput("unfreeze_shadow_b", bus_b.bcd_out, 20'h54321);
      button_in = 1'b0;
      doTick();
      doTick();

      // Reset mid-conversion at cycle 8
      @(negedge sysclk);
      bus_a.value_in    = 16'd999;
      bus_a.value_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge sysclk);
         bus_a.value_valid = 1'b0;
      end
      checkOutput("midconv_busy_before", bus_a.busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", bus_a.busy, 0);
      checkOutput("midreset_bcd_a", bus_a.bcd_out, 20'h00000);
      checkOutput("midreset_bcd_b", bus_b.bcd_out, 20'hFFFF0);
      saved_a = done_seen_a;
      saved_b = done_seen_b;
      @(negedge sysclk);
      rst_n = 1'b1;
      repeat (30) @(negedge sysclk);
      checkOutput("no_done_after_reset_a", done_seen_a, saved_a);
      checkOutput("no_done_after_reset_b", done_seen_b, saved_b);
      checkOutput("post_reset_bcd_a", bus_a.bcd_out, 20'h00000);

      checkOutput("queue_a_empty", q_a.size(), 0);
      checkOutput("queue_b_empty", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
